// File: rtl/dw_pw_scheduler_pkg.sv
// accel_pkg: shared scheduler types and defaults.
//   sched_state_t      - scheduler FSM state encoding (IDLE, RUN, DONE)
//   SINGLE_BANK_LAYERS - layers with index below this run depth/point serialised on bank 0
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

  localparam int unsigned SINGLE_BANK_LAYERS = 4;

endpackage

// File: rtl/dw_pw_scheduler_if.sv
// dw_pw_scheduler_if: layer control, engine handshakes and buffer bank status
// for the depthwise/pointwise scheduler.
//   master modport - layer controller and engines: drive layer, cfg_tiles,
//                    layer_start, depth33_done, point11_done; observe the rest
//   slave modport  - the scheduler: drives start pulses, bank selects,
//                    bank_full, busy, layer_done, err
interface dw_pw_scheduler_if #(
  parameter int unsigned TILE_W = 8
);

  logic [3:0]        layer;
  logic [TILE_W-1:0] cfg_tiles;
  logic              layer_start;
  logic              depth_start;
  logic              depth33_done;
  logic              point_start;
  logic              point11_done;
  logic              write_sel;
  logic              read_sel;
  logic [1:0]        bank_full;
  logic              busy;
  logic              layer_done;
  logic              err;

  modport master (
    output layer, cfg_tiles, layer_start, depth33_done, point11_done,
    input  depth_start, point_start, write_sel, read_sel, bank_full,
           busy, layer_done, err
  );

  modport slave (
    input  layer, cfg_tiles, layer_start, depth33_done, point11_done,
    output depth_start, point_start, write_sel, read_sel, bank_full,
           busy, layer_done, err
  );

endinterface

// File: rtl/dw_pw_scheduler_pingpong_tracker.sv
// pingpong_tracker: occupancy of the two intermediate-buffer banks and the
// write/read bank selects.
//   clk, rst_n         - clock, synchronous active-low reset
//   clear              - empty both banks and return both selects to bank 0
//   single_bank        - hold both selects at bank 0
//   wr_done / rd_done  - a depth tile filled / a point tile drained the selected bank
//   write_sel/read_sel - bank written by depthwise / read by pointwise
//   bank_full          - per-bank occupancy
//   can_write/can_read - selected write bank empty / selected read bank full
module pingpong_tracker (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       single_bank,
  input  logic       wr_done,
  input  logic       rd_done,
  output logic       write_sel,
  output logic       read_sel,
  output logic [1:0] bank_full,
  output logic       can_write,
  output logic       can_read
);

  logic [1:0] full_d;

  // Set before clear: in ping-pong mode the two indices always differ.
  always_comb begin
    full_d = bank_full;
    if (wr_done) full_d[write_sel] = 1'b1;
    if (rd_done) full_d[read_sel]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      bank_full <= '0;
      write_sel <= 1'b0;
      read_sel  <= 1'b0;
    end else begin
      bank_full <= full_d;
      write_sel <= single_bank ? 1'b0 : (write_sel ^ wr_done);
      read_sel  <= single_bank ? 1'b0 : (read_sel ^ rd_done);
    end
  end

  assign can_write = ~bank_full[write_sel];
  assign can_read  = bank_full[read_sel];

endmodule

// File: rtl/dw_pw_scheduler.sv
// dw_pw_scheduler: issues one depthwise and one pointwise start per tile around
// the ping-pong intermediate buffer, overlapping depth tile n+1 with point tile n
// (or serialising on bank 0 for early layers).
//   clk   - clock, rising edge
//   rst_n - synchronous reset, active low
//   bus   - dw_pw_scheduler_if slave: layer/cfg_tiles/layer_start in,
//           depth/point start-done handshakes, bank selects, bank_full,
//           busy, layer_done, err
module dw_pw_scheduler #(
  parameter int unsigned TILE_W             = 8,
  parameter int unsigned SINGLE_BANK_LAYERS = accel_pkg::SINGLE_BANK_LAYERS
) (
  input logic              clk,
  input logic              rst_n,
  dw_pw_scheduler_if.slave bus
);

  import accel_pkg::*;

  sched_state_t      state_q, state_d;
  logic [3:0]        layer_q;
  logic [TILE_W-1:0] tiles_q;
  logic [TILE_W-1:0] d_cnt;
  logic [TILE_W-1:0] p_cnt;
  logic              depth_if, point_if;
  logic              depth_start_q, point_start_q, layer_done_q, busy_q, err_q;
  logic              layer_done_d, busy_d;

  logic              accept, single_bank;
  logic              d_done_ok, p_done_ok, last_point;
  logic              depth_issue, point_issue;
  logic              can_write, can_read;
  logic              write_sel, read_sel;
  logic [1:0]        bank_full;

  assign accept      = (state_q == IDLE) && bus.layer_start;
  assign single_bank = 32'(layer_q) < SINGLE_BANK_LAYERS;

  // Done pulses only count against a tile actually in flight; anything else is a violation.
  assign d_done_ok   = bus.depth33_done && depth_if;
  assign p_done_ok   = bus.point11_done && point_if;
  assign last_point  = p_done_ok && ((p_cnt + TILE_W'(1)) == tiles_q);

  assign depth_issue = (state_q == RUN) && !depth_if && (d_cnt != tiles_q) && can_write;
  assign point_issue = (state_q == RUN) && !point_if && can_read;

  pingpong_tracker u_tracker (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (accept),
    .single_bank (single_bank),
    .wr_done     (d_done_ok),
    .rd_done     (p_done_ok),
    .write_sel   (write_sel),
    .read_sel    (read_sel),
    .bank_full   (bank_full),
    .can_write   (can_write),
    .can_read    (can_read)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // layer_done is registered: from RUN it fires with the move to DONE; a zero-tile
  // layer enters DONE first and fires one cycle later. DONE exits once it has fired.
  always_comb begin
    state_d      = state_q;
    layer_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.layer_start) state_d = (bus.cfg_tiles != '0) ? RUN : DONE;
      end
      RUN: begin
        if (last_point) begin
          state_d      = DONE;
          layer_done_d = 1'b1;
        end
      end
      DONE: begin
        if (layer_done_q) state_d = IDLE;
        else              layer_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      layer_q       <= '0;
      tiles_q       <= '0;
      d_cnt         <= '0;
      p_cnt         <= '0;
      depth_if      <= 1'b0;
      point_if      <= 1'b0;
      err_q         <= 1'b0;
      depth_start_q <= 1'b0;
      point_start_q <= 1'b0;
      layer_done_q  <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      if (accept) begin
        layer_q  <= bus.layer;
        tiles_q  <= bus.cfg_tiles;
        d_cnt    <= '0;
        p_cnt    <= '0;
        depth_if <= 1'b0;
        point_if <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if (depth_issue) begin
          d_cnt    <= d_cnt + TILE_W'(1);
          depth_if <= 1'b1;
        end else if (d_done_ok) begin
          depth_if <= 1'b0;
        end
        if (point_issue)    point_if <= 1'b1;
        else if (p_done_ok) point_if <= 1'b0;
        if (p_done_ok) p_cnt <= p_cnt + TILE_W'(1);
        if ((bus.depth33_done && !depth_if) || (bus.point11_done && !point_if)) err_q <= 1'b1;
      end
      depth_start_q <= depth_issue;
      point_start_q <= point_issue;
      layer_done_q  <= layer_done_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.depth_start = depth_start_q;
  assign bus.point_start = point_start_q;
  assign bus.layer_done  = layer_done_q;
  assign bus.busy        = busy_q;
  assign bus.err         = err_q;
  assign bus.write_sel   = write_sel;
  assign bus.read_sel    = read_sel;
  assign bus.bank_full   = bank_full;

endmodule

// File: tb/tb_dw_pw_scheduler.sv
// tb_dw_pw_scheduler: directed self-checking bench for dw_pw_scheduler.
module tb_dw_pw_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dw_pw_scheduler_if #(.TILE_W(8)) bus ();

  dw_pw_scheduler #(.TILE_W(8), .SINGLE_BANK_LAYERS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // results of run_layer
  int unsigned r_ds, r_ps, r_pd, r_wt, r_rt, r_ld, r_dbp;
  int unsigned r_first_ds_t, r_first_dd_t, r_first_ps_t, r_last_pd_t, r_ld_t, r_idle_t;
  logic        r_full11, r_serial, r_sel1, r_err, r_fin;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] outs();
    return {bus.depth_start, bus.point_start, bus.layer_done, bus.busy, bus.err,
            bus.write_sel, bus.read_sel, bus.bank_full};
  endfunction

  // Runs one layer with engine models that answer each start after a fixed latency.
  task automatic run_layer(input logic [3:0] lyr, input logic [7:0] n,
                           input int unsigned dlat, input int unsigned plat,
                           input int unsigned budget);
    int unsigned d_rem, p_rem, dd;
    logic prev_w, prev_r, fin;
    r_ds = 0; r_ps = 0; r_pd = 0; r_wt = 0; r_rt = 0; r_ld = 0; r_dbp = 0; dd = 0;
    r_first_ds_t = 0; r_first_dd_t = 0; r_first_ps_t = 0; r_last_pd_t = 0;
    r_ld_t = 0; r_idle_t = 0;
    r_full11 = 1'b0; r_serial = 1'b1; r_sel1 = 1'b0; r_err = 1'b0;
    d_rem = 0; p_rem = 0; fin = 1'b0;
    bus.layer = lyr; bus.cfg_tiles = n; bus.layer_start = 1'b1;
    step();
    bus.layer_start = 1'b0;
    prev_w = bus.write_sel; prev_r = bus.read_sel;
    for (int unsigned t = 1; t <= budget && !fin; t++) begin
      if (bus.depth_start) begin
        if (r_ds != r_pd) r_serial = 1'b0;
        if (r_pd == 0) r_dbp++;
        if (r_ds == 0) r_first_ds_t = t;
        r_ds++;
      end
      bus.depth33_done = 1'b0;
      bus.point11_done = 1'b0;
      if (d_rem > 0) begin
        d_rem--;
        if (d_rem == 0) begin
          bus.depth33_done = 1'b1;
          if (dd == 0) r_first_dd_t = t;
          dd++;
        end
      end
      if (p_rem > 0) begin
        p_rem--;
        if (p_rem == 0) begin
          bus.point11_done = 1'b1;
          r_pd++;
          r_last_pd_t = t;
        end
      end
      if (bus.depth_start) d_rem = dlat;
      if (bus.point_start) begin
        if (r_ps == 0) r_first_ps_t = t;
        r_ps++;
        p_rem = plat;
      end
      if (bus.bank_full == 2'b11) r_full11 = 1'b1;
      if (bus.write_sel !== prev_w) r_wt++;
      if (bus.read_sel !== prev_r) r_rt++;
      prev_w = bus.write_sel; prev_r = bus.read_sel;
      if (bus.write_sel || bus.read_sel) r_sel1 = 1'b1;
      if (bus.err) r_err = 1'b1;
      if (bus.layer_done) begin
        r_ld++;
        r_ld_t = t;
      end
      if (r_ld > 0 && !bus.busy) begin
        r_idle_t = t;
        fin = 1'b1;
      end
      step();
    end
    bus.depth33_done = 1'b0;
    bus.point11_done = 1'b0;
    r_fin = fin;
  endtask

  initial begin
    logic pulses;
    bus.layer = '0; bus.cfg_tiles = '0; bus.layer_start = 1'b0;
    bus.depth33_done = 1'b0; bus.point11_done = 1'b0;

    // reset state
    rst_n = 1'b0;
    step(); step();
    chk("reset_outs", 32'(outs()), 0);
    rst_n = 1'b1;
    step();

    // spurious point done in IDLE, then zero-tile layer
    bus.point11_done = 1'b1;
    step();
    bus.point11_done = 1'b0;
    chk("spur_err", 32'(bus.err), 1);
    chk("spur_idle_busy", 32'(bus.busy), 0);
    step();
    chk("err_sticky", 32'(bus.err), 1);
    bus.cfg_tiles = '0; bus.layer = 4'd5; bus.layer_start = 1'b1;
    step();
    bus.layer_start = 1'b0;
    chk("zero_c1_busy", 32'(bus.busy), 1);
    chk("zero_c1_err", 32'(bus.err), 0);
    chk("zero_c1_ld", 32'(bus.layer_done), 0);
    step();
    chk("zero_c2_ld", 32'(bus.layer_done), 1);
    chk("zero_c2_ds", 32'(bus.depth_start), 0);
    step();
    chk("zero_c3_busy", 32'(bus.busy), 0);
    chk("zero_c3_ld", 32'(bus.layer_done), 0);

    // ping-pong overlap
    run_layer(4'd5, 8'd3, 10, 20, 400);
    chk("pp_fin", 32'(r_fin), 1);
    chk("pp_depth_starts", r_ds, 3);
    chk("pp_point_starts", r_ps, 3);
    chk("pp_first_ds_cycle", r_first_ds_t, 2);
    chk("pp_handoff", r_first_ps_t - r_first_dd_t, 2);
    chk("pp_depth_before_p1", r_dbp, 2);
    chk("pp_wsel_toggles", r_wt, 3);
    chk("pp_rsel_toggles", r_rt, 3);
    chk("pp_layer_done", r_ld, 1);
    chk("pp_ld_latency", r_ld_t - r_last_pd_t, 1);
    chk("pp_idle_latency", r_idle_t - r_last_pd_t, 2);
    chk("pp_err", 32'(r_err), 0);

    // single-bank serialisation
    run_layer(4'd2, 8'd2, 10, 20, 400);
    chk("sb_fin", 32'(r_fin), 1);
    chk("sb_depth_starts", r_ds, 2);
    chk("sb_point_starts", r_ps, 2);
    chk("sb_serial", 32'(r_serial), 1);
    chk("sb_sel_zero", 32'(r_sel1), 0);
    chk("sb_layer_done", r_ld, 1);

    // back-pressure
    run_layer(4'd6, 8'd4, 10, 100, 2000);
    chk("bp_fin", 32'(r_fin), 1);
    chk("bp_full11", 32'(r_full11), 1);
    chk("bp_depth_before_p1", r_dbp, 2);
    chk("bp_depth_starts", r_ds, 4);
    chk("bp_point_starts", r_ps, 4);
    chk("bp_err", 32'(r_err), 0);

    // simultaneous dones, then reset mid-layer
    bus.layer = 4'd7; bus.cfg_tiles = 8'd4; bus.layer_start = 1'b1;
    step();
    bus.layer_start = 1'b0;
    step();
    chk("sim_ds1", 32'(bus.depth_start), 1);
    step();
    bus.depth33_done = 1'b1;
    step();
    bus.depth33_done = 1'b0;
    chk("sim_full_a", 32'(bus.bank_full), 32'b01);
    chk("sim_wsel_a", 32'(bus.write_sel), 1);
    step();
    chk("sim_ds2", 32'(bus.depth_start), 1);
    chk("sim_ps1", 32'(bus.point_start), 1);
    step();
    bus.depth33_done = 1'b1; bus.point11_done = 1'b1;
    step();
    bus.depth33_done = 1'b0; bus.point11_done = 1'b0;
    chk("sim_full_b", 32'(bus.bank_full), 32'b10);
    chk("sim_sels_b", 32'({bus.write_sel, bus.read_sel}), 32'b01);
    chk("sim_no_start", 32'({bus.depth_start, bus.point_start}), 0);
    step();
    chk("sim_ds3", 32'(bus.depth_start), 1);
    chk("sim_ps2", 32'(bus.point_start), 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_mid_outs", 32'(outs()), 0);
    pulses = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.depth_start || bus.point_start || bus.layer_done || bus.busy) pulses = 1'b1;
    end
    chk("rst_quiet", 32'(pulses), 0);

    // layer at the single-bank boundary runs ping-pong
    run_layer(4'd4, 8'd2, 6, 9, 400);
    chk("post_fin", 32'(r_fin), 1);
    chk("post_depth_starts", r_ds, 2);
    chk("post_point_starts", r_ps, 2);
    chk("post_wsel_toggles", r_wt, 2);
    chk("post_layer_done", r_ld, 1);
    chk("post_err", 32'(r_err), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dw_pw_scheduler.md
# dw_pw_scheduler

Sequences the depthwise 3x3 engine and the pointwise 1x1 engine around the depthwise-to-pointwise intermediate buffer. It tracks occupancy of the two ping-pong banks, issues one start pulse per tile to each engine, and drives the buffer's bank selects. For layers below `SINGLE_BANK_LAYERS` it serialises depth then point on bank 0; otherwise depth tile n+1 overlaps point tile n.

## Interface
- `TILE_W`, default 8: width of the per-layer tile count.
- `SINGLE_BANK_LAYERS`, default 4: layers with index below this value run in single-bank mode.

Ports (single clock domain; reset is synchronous and active-low):
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst_n`  in  1: synchronous reset, active low.
- `layer`  in  4: current layer index; sampled only on an accepted `layer_start`.
- `cfg_tiles`  in  TILE_W: number of depth/point tiles in the layer; sampled with `layer_start`.
- `layer_start`  in  1: one-cycle request to run a layer.
- `depth_start`  out  1: one-cycle pulse; the depthwise engine begins a tile.
- `depth33_done`  in  1: one-cycle pulse; a depthwise tile is fully written.
- `point_start`  out  1: one-cycle pulse; the pointwise engine begins a tile.
- `point11_done`  in  1: one-cycle pulse; a pointwise tile is fully read.
- `write_sel`  out  1: bank the depthwise engine writes.
- `read_sel`  out  1: bank the pointwise engine reads.
- `bank_full`  out  2: per-bank occupancy flag.
- `busy`  out  1: high in every state other than IDLE.
- `layer_done`  out  1: one-cycle pulse after the last point tile completes.
- `err`  out  1: sticky protocol-violation flag.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `layer_start` with `cfg_tiles` != 0:
    - latch `layer` and `cfg_tiles`;
    - clear counters, `bank_full`, `write_sel`, `read_sel` and `err`;
    - go to RUN.
  - `layer_start` with `cfg_tiles` == 0: go to DONE without issuing any starts.
- **RUN, depth issue**: raise `depth_start` when all of the following hold:
  - no depth tile in flight;
  - depth issued count < `cfg_tiles`;
  - `bank_full[write_sel]` == 0.
  - On issue, increment the issued count and set depth-in-flight.
- **RUN, depth completion** on `depth33_done`:
  - set `bank_full[write_sel]`;
  - clear depth-in-flight;
  - toggle `write_sel`, except in single-bank mode.
- **RUN, point issue**: raise `point_start` when no point tile is in flight and `bank_full[read_sel]` == 1. Set point-in-flight.
- **RUN, point completion** on `point11_done`:
  - clear `bank_full[read_sel]`;
  - clear point-in-flight;
  - toggle `read_sel`, except in single-bank mode;
  - increment the point done count.
  - When the count reaches `cfg_tiles`, go to DONE.
- **Single-bank mode** (latched layer < `SINGLE_BANK_LAYERS`): both selects are held at 0. Serialisation then follows from the single occupancy flag.
- **DONE**: pulse `layer_done` for one cycle, then return to IDLE.
- **Simultaneous events**: `depth33_done` and `point11_done` in the same cycle are both applied. They always target different banks in ping-pong mode.
- **Protocol violations**: a done pulse with no tile of that kind in flight, or any done pulse in IDLE, is ignored and sets `err`. `err` clears only on reset or an accepted `layer_start`.
- `layer_start` while `busy` is ignored and does not set `err`.
- Counters are `TILE_W` bits wide and compared for equality; no wrap-around occurs within a layer.

## Timing
- All outputs are registered. Reset values: `depth_start`, `point_start`, `layer_done`, `busy`, `err`, `write_sel`, `read_sel` = 0; `bank_full` = 2'b00; state = IDLE.
- `layer_start` high in cycle c: `busy` is high from c+1 and the first `depth_start` is high in c+2.
- A done pulse in cycle c: `bank_full` and the select change are visible in c+1; the dependent start pulse is high in c+2.
  - Depth-to-point handoff latency is therefore 2 cycles.
  - The same engine is never restarted earlier than 2 cycles after its done.
- The last `point11_done` in cycle c: `layer_done` in c+1, `busy` low in c+2.
- Reset asserted in any cycle returns every register to its reset value at the next edge. In-flight tiles are abandoned and no start or done pulse is emitted afterwards.

## Structure
- Shared package `accel_pkg` holds:
  - state enum `sched_state_t` (IDLE, RUN, DONE);
  - constant `SINGLE_BANK_LAYERS`.
- One natural sub-module, `pingpong_tracker`: holds the 2-bit occupancy, both selects and the single-bank gating, and exposes `can_write`/`can_read`. The FSM and counters stay in the top module.

## Test plan
- **Ping-pong overlap**: layer=5, tiles=3; depth done 10 cycles after each start, point done 20 cycles after each start.
  - 3 `depth_start` and 3 `point_start` pulses.
  - Second depth tile begins before the first point tile finishes.
  - `write_sel`/`read_sel` toggle 3 times each; `layer_done` once; `err`=0.
- **Single-bank serialisation**: layer=2, tiles=2.
  - Each `depth_start` occurs only after the preceding `point11_done`.
  - Both selects stay 0 throughout.
- **Back-pressure**: layer=6, tiles=4, pointwise done held off for 100 cycles.
  - After 2 depth tiles, `bank_full`=2'b11 and no third `depth_start` until `point11_done`.
- **Simultaneous dones**: `depth33_done` and `point11_done` in the same cycle.
  - One bank sets and the other clears in the same cycle.
  - Both next starts appear 2 cycles later.
- **Errors and zero tiles**:
  - Spurious `point11_done` in IDLE sets `err`.
  - `cfg_tiles`=0 gives `layer_done` in c+2 with no starts and clears `err`.
- **Reset mid-layer**: `rst_n` low for 1 cycle during RUN at tile 2.
  - All outputs return to reset values at the next edge; a following `layer_start` runs normally.
